sram_axi_bridge: RTL



---
 rtl/sram_axi_bridge_pkg.sv | 34 +++
 rtl/sram_axi_bridge_rd_ctrl.sv | 111 +++++++++++
 rtl/sram_axi_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg
//   Shared definitions for the SRAM-to-AXI3 bridge: default AXI IDs, the
//   read/write FSM state encodings, the fixed AXI attribute values driven on
//   every transaction, and the SRAM-size to AXI-size conversion.
package sram_axi_bridge_pkg;

    localparam logic [3:0] INST_ID_DEF    = 4'd0;
    localparam logic [3:0] DATA_ID_DEF    = 4'd1;

    // Single-beat INCR transactions, normal access, no caching hints.
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } wr_state_t;

    // SRAM size encodes bytes as 2^size, same as AXI; AXI just has one more bit.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_rd_ctrl.sv
// axi_rd_ctrl
//   AR/R channel controller with instruction/data read arbitration.
//   One read outstanding at a time. Data reads win over instruction reads;
//   data reads additionally wait for the write path to be idle so a load can
//   never overtake an earlier store.
// Ports:
//   clk, reset                  clock, async active-high reset
//   inst_req/addr/size          instruction read request
//   data_req/wr/addr/size       data request (only reads are taken here)
//   w_idle                      write path has nothing in flight
//   inst_addr_ok, data_addr_ok  same-cycle acceptance strobes
//   data_busy                   a data read is outstanding
//   arid/araddr/arsize/arvalid/arready   AXI AR channel (subset)
//   rid/rvalid/rready           AXI R channel handshake
//   inst_data_ok, data_data_ok  read completion strobes, routed by rid
module axi_rd_ctrl
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic        w_idle,
    output logic        inst_addr_ok,
    output logic        data_addr_ok,
    output logic        data_busy,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic        rvalid,
    output logic        rready,
    output logic        inst_data_ok,
    output logic        data_data_ok
);

    rd_state_t   state, state_nx;
    logic        data_rd_req;
    logic        take_data;
    logic        take_inst;
    logic        is_data_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;

    always_comb begin
        data_rd_req = data_req & ~data_wr;
        take_data   = 1'b0;
        take_inst   = 1'b0;
        state_nx    = state;
        case (state)
            R_IDLE: begin
                take_data = data_rd_req & w_idle;
                // Any pending data read, even one held off by a store, blocks
                // the instruction side this cycle.
                take_inst = inst_req & ~data_rd_req;
                if (take_data || take_inst) state_nx = R_AR;
            end
            R_AR:    if (arready) state_nx = R_R;
            R_R:     if (rvalid)  state_nx = R_IDLE;
            default: state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            is_data_q <= 1'b0;
            araddr_q  <= 32'd0;
            arsize_q  <= 3'd0;
        end else begin
            state     <= state_nx;
            arvalid_q <= (state_nx == R_AR);
            rready_q  <= (state_nx == R_R);
            if (take_data) begin
                is_data_q <= 1'b1;
                araddr_q  <= data_addr;
                arsize_q  <= axi_size(data_size);
            end else if (take_inst) begin
                is_data_q <= 1'b0;
                araddr_q  <= inst_addr;
                arsize_q  <= axi_size(inst_size);
            end
        end
    end

    assign inst_addr_ok = take_inst;
    assign data_addr_ok = take_data;
    assign data_busy    = (state != R_IDLE) & is_data_q;
    assign arid         = is_data_q ? DATA_ID : INST_ID;
    assign araddr       = araddr_q;
    assign arsize       = arsize_q;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign data_data_ok = rready_q & rvalid & (rid == DATA_ID);
    assign inst_data_ok = rready_q & rvalid & (rid != DATA_ID);

endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Merges the core's instruction and data SRAM-like ports onto one AXI3
//   master. One read and one write may be outstanding; the write path (AW/W/B)
//   lives here, the read path in axi_rd_ctrl.
// Ports:
//   clk, reset                  clock, async active-high reset
//   inst_sram_*                 instruction request/response (writes ignored)
//   data_sram_*                 data request/response
//   ar*/r*                      AXI read address / read data channels
//   aw*/w*/b*                   AXI write address / write data / response
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    wr_state_t   w_state, w_state_nx;
    logic        w_idle;
    logic        wr_take;
    logic        rd_data_busy;
    logic        rd_data_addr_ok;
    logic        rd_data_ok;
    logic        awvalid_q, wvalid_q, bready_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [2:0]  awsize_q;
    logic [3:0]  wstrb_q;

    // Inputs the bridge deliberately ignores (no error reporting, no inst
    // writes, single-beat bursts only).
    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         rresp, rlast, bid, bresp};

    axi_rd_ctrl #(
        .INST_ID (INST_ID),
        .DATA_ID (DATA_ID)
    ) u_rd_ctrl (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_sram_req),
        .inst_addr    (inst_sram_addr),
        .inst_size    (inst_sram_size),
        .data_req     (data_sram_req),
        .data_wr      (data_sram_wr),
        .data_addr    (data_sram_addr),
        .data_size    (data_sram_size),
        .w_idle       (w_idle),
        .inst_addr_ok (inst_sram_addr_ok),
        .data_addr_ok (rd_data_addr_ok),
        .data_busy    (rd_data_busy),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rvalid       (rvalid),
        .rready       (rready),
        .inst_data_ok (inst_sram_data_ok),
        .data_data_ok (rd_data_ok)
    );

    assign w_idle = (w_state == W_IDLE);

    always_comb begin
        wr_take    = 1'b0;
        w_state_nx = w_state;
        case (w_state)
            W_IDLE: begin
                wr_take = data_sram_req & data_sram_wr & ~rd_data_busy;
                if (wr_take) w_state_nx = W_AW;
            end
            // AW and W complete independently; move on once neither is pending.
            W_AW: if ((~awvalid_q | awready) && (~wvalid_q | wready)) w_state_nx = W_B;
            W_B:     if (bvalid) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state   <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= 32'd0;
            awsize_q  <= 3'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
        end else begin
            w_state  <= w_state_nx;
            bready_q <= (w_state_nx == W_B);
            case (w_state)
                W_IDLE: begin
                    awvalid_q <= wr_take;
                    wvalid_q  <= wr_take;
                    if (wr_take) begin
                        awaddr_q <= data_sram_addr;
                        awsize_q <= axi_size(data_sram_size);
                        wdata_q  <= data_sram_wdata;
                        wstrb_q  <= data_sram_wstrb;
                    end
                end
                W_AW: begin
                    awvalid_q <= awvalid_q & ~awready;
                    wvalid_q  <= wvalid_q & ~wready;
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_sram_addr_ok = rd_data_addr_ok | wr_take;
    // Only one data transaction is ever outstanding, so these never collide.
    assign data_sram_data_ok = rd_data_ok | (bready_q & bvalid);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NONE;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

    assign awid    = DATA_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = awsize_q;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NONE;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;
    assign awvalid = awvalid_q;

    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule
